// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder FSM states, FIPS 180-4 padding constants,
// initial hash values and the message bit-length helper.
package sha256_pkg;

  localparam int LEN_W_DEF = 32;

  localparam logic [31:0] PAD_MARKER  = 32'h8000_0000;
  localparam logic [3:0]  LEN_HI_SLOT = 4'd14;
  localparam logic [3:0]  LEN_LO_SLOT = 4'd15;
  localparam logic [3:0]  LAST_SLOT   = 4'd15;
  // Highest slot at which the marker still leaves room for the length words.
  localparam logic [3:0]  LAST_LEN_FIT_SLOT = 4'd13;

  localparam logic [31:0] SHA256_H0 = 32'h6a09_e667;
  localparam logic [31:0] SHA256_H1 = 32'hbb67_ae85;
  localparam logic [31:0] SHA256_H2 = 32'h3c6e_f372;
  localparam logic [31:0] SHA256_H3 = 32'ha54f_f53a;
  localparam logic [31:0] SHA256_H4 = 32'h510e_527f;
  localparam logic [31:0] SHA256_H5 = 32'h9b05_688c;
  localparam logic [31:0] SHA256_H6 = 32'h1f83_d9ab;
  localparam logic [31:0] SHA256_H7 = 32'h5be0_cd19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FILL,
    ST_PAD,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } pad_state_e;

  // Message length in bits from a zero-extended byte count.
  function automatic logic [63:0] bitlen_of(input logic [60:0] byte_count);
    return {byte_count, 3'b000};
  endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Byte-message word stream feeding the SHA-256 padder.
interface sha256_padder_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic [1:0]  s_bytes;
  logic        s_ready;

  modport master (output s_data, s_valid, s_last, s_bytes, input s_ready);
  modport slave  (input s_data, s_valid, s_last, s_bytes, output s_ready);
endinterface

// File: rtl/sha256_pad_word.sv
// Merges the 0x80 marker into a partial final word and zeroes the bytes after it.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] data,
  input  logic        last,
  input  logic [1:0]  bytes,
  output logic [31:0] word,
  output logic [2:0]  byte_inc,
  output logic        merged
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    word     = data;
    byte_inc = 3'd4;
    merged   = 1'b0;
    if (last) begin
      unique case (bytes)
        2'd1: begin
          word     = {data[31:24], PAD_MARKER[31:8]};
          byte_inc = 3'd1;
          merged   = 1'b1;
        end
        2'd2: begin
          word     = {data[31:16], PAD_MARKER[31:16]};
          byte_inc = 3'd2;
          merged   = 1'b1;
        end
        2'd3: begin
          word     = {data[31:8], PAD_MARKER[31:24]};
          byte_inc = 3'd3;
          merged   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// Frames a byte message into padded 512-bit blocks and sequences the SHA-256
// core through clear, per-block start/done and final-digest notification.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  sha256_padder_if.slave   s,
  output logic             core_clear,
  output logic [511:0]     blk_data,
  output logic             blk_start,
  input  logic             blk_done,
  output logic             msg_done,
  output logic             busy
);

  pad_state_e         state_q, state_d;
  logic [15:0][31:0]  blk_q;
  logic [3:0]         idx_q;
  logic [LEN_W-1:0]   byte_cnt_q;
  logic               marker_pending_q;
  logic               len_ok_q;
  logic               final_q;
  logic               input_done_q;

  logic               s_ready_c;
  logic               accept;
  logic [31:0]        last_word;
  logic [2:0]         byte_inc;
  logic               merged;
  logic [31:0]        pad_fill;
  logic [63:0]        bitlen;
  logic               pad_len_ok;

  sha256_pad_word u_pad_word (
    .data     (s.s_data),
    .last     (s.s_last),
    .bytes    (s.s_bytes),
    .word     (last_word),
    .byte_inc (byte_inc),
    .merged   (merged)
  );

  assign s.s_ready  = s_ready_c;
  assign accept     = s_ready_c && s.s_valid;
  assign blk_data   = blk_q;
  assign bitlen     = bitlen_of(61'(byte_cnt_q));
  assign pad_len_ok = len_ok_q && !marker_pending_q;

  // NOTE: state is a flop, so it is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    s_ready_c  = 1'b0;
    core_clear = 1'b0;
    blk_start  = 1'b0;
    msg_done   = 1'b0;
    busy       = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE:  if (s.s_valid) state_d = ST_CLEAR;
      ST_CLEAR: begin
        core_clear = 1'b1;
        state_d    = ST_FILL;
      end
      ST_FILL: begin
        s_ready_c = 1'b1;
        if (s.s_valid) begin
          if (idx_q == LAST_SLOT) state_d = ST_ISSUE;
          else if (s.s_last)      state_d = ST_PAD;
        end
      end
      ST_PAD:   if (idx_q == LAST_SLOT) state_d = ST_ISSUE;
      ST_ISSUE: begin
        blk_start = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (blk_done) begin
          if (final_q)           state_d = ST_DONE;
          else if (input_done_q) state_d = ST_PAD;
          else                   state_d = ST_FILL;
        end
      end
      ST_DONE: begin
        msg_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending marker goes first; the length only lands once the marker fits below slot 14.
  always_comb begin
    pad_fill = '0;
    if (marker_pending_q)                       pad_fill = PAD_MARKER;
    else if (len_ok_q && idx_q == LEN_HI_SLOT)  pad_fill = bitlen[63:32];
    else if (len_ok_q && idx_q == LEN_LO_SLOT)  pad_fill = bitlen[31:0];
  end

  // NOTE: the block register is reset because blk_data must read zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_q            <= '0;
      idx_q            <= '0;
      byte_cnt_q       <= '0;
      marker_pending_q <= 1'b0;
      len_ok_q         <= 1'b0;
      final_q          <= 1'b0;
      input_done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          idx_q            <= '0;
          byte_cnt_q       <= '0;
          marker_pending_q <= 1'b0;
          len_ok_q         <= 1'b0;
          final_q          <= 1'b0;
          input_done_q     <= 1'b0;
        end
        ST_FILL: begin
          if (accept) begin
            blk_q[idx_q] <= last_word;
            idx_q        <= idx_q + 4'd1;
            byte_cnt_q   <= byte_cnt_q + LEN_W'(byte_inc);
            if (s.s_last) begin
              input_done_q <= 1'b1;
              if (merged) len_ok_q         <= (idx_q <= LAST_LEN_FIT_SLOT);
              else        marker_pending_q <= 1'b1;
            end
          end
        end
        ST_PAD: begin
          blk_q[idx_q] <= pad_fill;
          idx_q        <= idx_q + 4'd1;
          if (marker_pending_q) begin
            marker_pending_q <= 1'b0;
            len_ok_q         <= (idx_q <= LAST_LEN_FIT_SLOT);
          end
          if (idx_q == LAST_SLOT) final_q <= pad_len_ok;
        end
        ST_WAIT: begin
          if (blk_done) begin
            idx_q <= '0;
            // A fresh padding-only block always has room for the length.
            if (!final_q && input_done_q) len_ok_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder with a behavioural SHA-256 core model.
module tb_sha256_padder;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  logic         clk;
  logic         reset_n;
  logic         core_clear;
  logic [511:0] blk_data;
  logic         blk_start;
  logic         blk_done;
  logic         msg_done;
  logic         busy;
  logic         model_done;
  logic         stray_done;

  sha256_padder_if s_if ();

  sha256_padder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s          (s_if),
    .core_clear (core_clear),
    .blk_data   (blk_data),
    .blk_start  (blk_start),
    .blk_done   (blk_done),
    .msg_done   (msg_done),
    .busy       (busy)
  );

  assign blk_done = model_done | stray_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int timeouts = 0;

  // Observations gathered by the core model.
  int           cyc = 0;
  int           clears = 0;
  int           starts = 0;
  int           msgs = 0;
  int           done_cyc = 0;
  int           msg_lat = -1;
  int           bp_viol = 0;
  int           stable_viol = 0;
  logic [511:0] blk_log [$];
  logic [255:0] digest = '0;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e,  hin[95:64] + f,   hin[63:32] + g,   hin[31:0] + h};
  endfunction

  // Core model: latches the block on blk_start, answers with blk_done 4 cycles later.
  initial begin
    logic [511:0] core_blk;
    int           core_cnt;
    bit           core_busy;
    core_blk   = '0;
    core_cnt   = 0;
    core_busy  = 1'b0;
    model_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      model_done = 1'b0;
      if (!reset_n) begin
        core_busy = 1'b0;
        continue;
      end
      if (core_clear) begin
        clears++;
        digest = H_INIT;
      end
      if (msg_done) begin
        msgs++;
        msg_lat = cyc - done_cyc;
      end
      if (core_busy && s_if.s_ready) bp_viol++;
      if (core_busy && blk_data !== core_blk) stable_viol++;
      if (blk_start) begin
        starts++;
        blk_log.push_back(blk_data);
        core_blk  = blk_data;
        core_cnt  = 3;
        core_busy = 1'b1;
      end else if (core_busy) begin
        if (core_cnt == 0) begin
          digest     = compress(digest, core_blk);
          model_done = 1'b1;
          done_cyc   = cyc;
          core_busy  = 1'b0;
        end else begin
          core_cnt--;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(4 * i);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  function automatic logic [511:0] pat_block(input int first, input int n);
    logic [15:0][31:0] blk;
    blk = '0;
    for (int k = 0; k < n; k++) blk[k] = pat(first + k);
    return blk;
  endfunction

  // Called at a negedge; returns at the negedge after the word was transferred.
  task automatic send(input logic [31:0] d, input logic last, input logic [1:0] nb);
    int t;
    t = 0;
    s_if.s_data  = d;
    s_if.s_valid = 1'b1;
    s_if.s_last  = last;
    s_if.s_bytes = nb;
    while (s_if.s_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeouts++;
    @(negedge clk);
  endtask

  task automatic idle_in();
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    s_if.s_bytes = 2'd0;
  endtask

  task automatic send_msg(input int nwords, input logic [1:0] last_bytes, input bit with_last);
    for (int i = 0; i < nwords; i++)
      send(pat(i), with_last && (i == nwords - 1), last_bytes);
    idle_in();
  endtask

  task automatic wait_msg(output bit ok);
    int m0;
    m0 = msgs;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (msgs != m0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [15:0][31:0] e;
    bit ok;
    int s0;

    reset_n    = 1'b0;
    stray_done = 1'b0;
    s_if.s_data = '0;
    idle_in();
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, s_if.s_ready, core_clear, blk_start, msg_done, blk_data}, '0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // "abc"
    blk_log.delete(); s0 = starts;
    send(32'h61626300, 1'b1, 2'd3); idle_in();
    wait_msg(ok);
    check("abc_done", ok, 1);
    check("abc_starts", starts - s0, 1);
    e = '0; e[0] = 32'h61626380; e[15] = 32'h18;
    check("abc_block", blk_log[0], e);
    check("abc_digest", digest, ABC_DIGEST);
    check("abc_msg_done_latency", msg_lat, 1);

    // single byte
    blk_log.delete(); s0 = starts;
    send(32'hAB123456, 1'b1, 2'd1); idle_in();
    wait_msg(ok);
    check("one_byte_starts", starts - s0, 1);
    e = '0; e[0] = 32'hAB800000; e[15] = 32'h8;
    check("one_byte_block", blk_log[0], e);

    // 56 bytes: marker pending into slot 14, length spills to a second block
    blk_log.delete(); s0 = starts;
    send_msg(14, 2'd0, 1'b1);
    wait_msg(ok);
    check("b56_starts", starts - s0, 2);
    e = pat_block(0, 14); e[14] = 32'h80000000;
    check("b56_block0", blk_log[0], e);
    e = '0; e[15] = 32'h1C0;
    check("b56_block1", blk_log[1], e);

    // 64 bytes: issue right after slot 15, marker opens the second block
    blk_log.delete(); s0 = starts;
    send_msg(16, 2'd0, 1'b1);
    wait_msg(ok);
    check("b64_starts", starts - s0, 2);
    check("b64_block0", blk_log[0], pat_block(0, 16));
    e = '0; e[0] = 32'h80000000; e[15] = 32'h200;
    check("b64_block1", blk_log[1], e);

    // 55 bytes: marker merged into slot 13, length still fits
    blk_log.delete(); s0 = starts;
    send_msg(14, 2'd3, 1'b1);
    wait_msg(ok);
    check("b55_starts", starts - s0, 1);
    e = pat_block(0, 13); e[13] = 32'h34353680; e[15] = 32'h1B8;
    check("b55_block", blk_log[0], e);

    // 62 bytes: marker merged into slot 15
    blk_log.delete(); s0 = starts;
    send_msg(16, 2'd2, 1'b1);
    wait_msg(ok);
    check("b62_starts", starts - s0, 2);
    e = pat_block(0, 15); e[15] = 32'h3C3D8000;
    check("b62_block0", blk_log[0], e);
    e = '0; e[15] = 32'h1F0;
    check("b62_block1", blk_log[1], e);

    // 80 bytes: s_valid stays high across the first WAIT
    blk_log.delete(); s0 = starts;
    send_msg(20, 2'd0, 1'b1);
    wait_msg(ok);
    check("b80_starts", starts - s0, 2);
    check("b80_block0", blk_log[0], pat_block(0, 16));
    e = pat_block(16, 4); e[4] = 32'h80000000; e[15] = 32'h280;
    check("b80_block1", blk_log[1], e);
    check("backpressure_ready_low", bp_viol, 0);

    // stray blk_done while idle
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    check("stray_done_idle", {busy, msg_done, blk_start}, 0);

    // reset while waiting on the core
    s0 = starts;
    send_msg(16, 2'd0, 1'b0);
    for (int t = 0; t < 50 && starts == s0; t++) @(negedge clk);
    check("rst_reached_wait", starts - s0, 1);
    reset_n = 1'b0;
    #1;
    check("rst_outputs", {busy, s_if.s_ready, core_clear, blk_start, msg_done, blk_data}, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    blk_log.delete(); s0 = starts;
    send(32'h61626300, 1'b1, 2'd3); idle_in();
    wait_msg(ok);
    check("abc2_done", ok, 1);
    check("abc2_starts", starts - s0, 1);
    check("abc2_digest", digest, ABC_DIGEST);

    check("clear_pulses", clears, 9);
    check("blk_data_stable", stable_viol, 0);
    check("send_timeouts", timeouts, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
